// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that owns the register file write port and, optionally,
// zero-sweeps x1..x31 after reset for register files without their own reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | post-reset; sweeping x1..x31 to zero (or passing straight to RUN)
// ST_RUN  | arbitrating writeback requesters; terminal until reset
module regfile_wb_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [5*NUM_REQ-1:0]    req_addr,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic                    writeEnable,
    output logic [4:0]              writeAddr,
    output logic [31:0]             writeData,
    output logic                    init_done,
    output logic [CNT_W-1:0]        contention
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam logic [SUM_W-1:0] NUM_REQ_W = SUM_W'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [4:0]       sweep_cnt;

    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] grant_next;
    logic [SUM_W-1:0] scan_sum;
    logic [PTR_W-1:0] scan_idx;
    logic [4:0]       sel_addr;
    logic [31:0]      sel_data;
    logic [2:0]       valid_cnt;
    logic             multi_valid;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        valid_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
            valid_cnt = valid_cnt + {2'b00, req_valid[k]};
        end
        multi_valid = (valid_cnt >= 3'd2);
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_RUN && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    assign sel_addr   = req_addr[5*int'(grant_idx) +: 5];
    assign sel_data   = req_data[32*int'(grant_idx) +: 32];
    assign init_done  = (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_INIT;
            rr_ptr      <= '0;
            sweep_cnt   <= 5'd1;
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
            contention  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (CLEAR_ON_RESET != 0) begin
                        writeEnable <= 1'b1;
                        writeAddr   <= sweep_cnt;
                        writeData   <= '0;
                        sweep_cnt   <= sweep_cnt + 5'd1;
                        if (sweep_cnt == 5'd31) begin
                            state <= ST_RUN;
                        end
                    end else begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    writeEnable <= 1'b0;
                    if (grant_any) begin
                        rr_ptr <= grant_next;
                        // x0 writes are consumed but never reach the register file.
                        if (sel_addr != 5'd0) begin
                            writeEnable <= 1'b1;
                            writeAddr   <= sel_addr;
                            writeData   <= sel_data;
                        end
                    end
                    if (multi_valid && contention != '1) begin
                        contention <= contention + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a 2-requester swept instance and a 3-requester
// unswept instance with a 2-bit contention counter, checked against a behavioural model.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  va;
    logic [9:0]  aa;
    logic [63:0] da;
    logic [1:0]  rdy_a;
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        id_a;
    logic [15:0] ct_a;

    logic [2:0]  vb;
    logic [14:0] ab;
    logic [95:0] db;
    logic [2:0]  rdy_b;
    logic        we_b;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic        id_b;
    logic [1:0]  ct_b;

    regfile_wb_arbiter #(.NUM_REQ(2), .CLEAR_ON_RESET(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .req_valid(va), .req_ready(rdy_a),
        .req_addr(aa), .req_data(da), .writeEnable(we_a), .writeAddr(wa_a),
        .writeData(wd_a), .init_done(id_a), .contention(ct_a)
    );

    regfile_wb_arbiter #(.NUM_REQ(3), .CLEAR_ON_RESET(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .req_valid(vb), .req_ready(rdy_b),
        .req_addr(ab), .req_data(db), .writeEnable(we_b), .writeAddr(wa_b),
        .writeData(wd_b), .init_done(id_b), .contention(ct_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    // Behavioural model: sweep list, round-robin scan order, saturating counter.
    int          m_run   [2];
    int          m_sweep [2];
    int          m_rr    [2];
    int          m_cont  [2];
    int          m_known [2];
    logic        m_we    [2];
    logic [4:0]  m_addr  [2];
    logic [31:0] m_data  [2];

    function automatic int model_grant(input int n, input int rr, input logic [3:0] v);
        for (int k = 0; k < n; k++) begin
            if (v[(rr + k) % n]) return (rr + k) % n;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [3:0]   v, r, exp_r;
            logic [19:0]  ad;
            logic [127:0] dt;
            logic         we, ini;
            logic [4:0]   wa, a;
            logic [31:0]  wd;
            int           ct, n, g, cmax;
            bit           clr;
            if (d == 0) begin
                v = {2'b0, va}; r = {2'b0, rdy_a}; ad = {10'b0, aa}; dt = {64'b0, da};
                we = we_a; wa = wa_a; wd = wd_a; ini = id_a; ct = int'(ct_a);
                n = 2; cmax = 65535; clr = 1'b1;
            end else begin
                v = {1'b0, vb}; r = {1'b0, rdy_b}; ad = {5'b0, ab}; dt = {32'b0, db};
                we = we_b; wa = wa_b; wd = wd_b; ini = id_b; ct = int'(ct_b);
                n = 3; cmax = 3; clr = 1'b0;
            end
            if (reset) begin
                chk("rst_we", d, we, 0);
                chk("rst_addr", d, wa, 0);
                chk("rst_data", d, wd, 0);
                chk("rst_ready", d, r, 0);
                chk("rst_init", d, ini, 0);
                chk("rst_cont", d, ct, 0);
                m_run[d] = 0; m_sweep[d] = 1; m_rr[d] = 0; m_cont[d] = 0; m_known[d] = 1;
                m_we[d] = 1'b0; m_addr[d] = '0; m_data[d] = '0;
            end else begin
                g = (m_run[d] != 0) ? model_grant(n, m_rr[d], v) : -1;
                exp_r = (g >= 0) ? 4'(1 << g) : 4'b0;
                chk("cmp_ready", d, r, exp_r);
                chk("cmp_init", d, ini, (m_run[d] != 0));
                chk("cmp_we", d, we, m_we[d]);
                chk("cmp_cont", d, ct, m_cont[d]);
                if (m_we[d] || m_known[d] != 0) begin
                    chk("cmp_addr", d, wa, m_addr[d]);
                    chk("cmp_data", d, wd, m_data[d]);
                end
                if (m_run[d] == 0) begin
                    if (clr) begin
                        m_we[d] = 1'b1; m_addr[d] = 5'(m_sweep[d]); m_data[d] = '0; m_known[d] = 1;
                        if (m_sweep[d] == 31) m_run[d] = 1;
                        m_sweep[d]++;
                    end else begin
                        m_run[d] = 1;
                    end
                end else begin
                    if ($countones(v) >= 2 && m_cont[d] < cmax) m_cont[d]++;
                    m_we[d] = 1'b0;
                    if (g >= 0) begin
                        a = ad[5*g +: 5];
                        if (a != 0) begin
                            m_we[d] = 1'b1; m_addr[d] = a; m_data[d] = dt[32*g +: 32]; m_known[d] = 1;
                        end else begin
                            m_known[d] = 0;
                        end
                        m_rr[d] = (g + 1) % n;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int i, input bit v, input logic [4:0] a, input logic [31:0] dt);
        va[i] = v; aa[5*i +: 5] = a; da[32*i +: 32] = dt;
    endtask

    task automatic set_b(input int i, input bit v, input logic [4:0] a, input logic [31:0] dt);
        vb[i] = v; ab[5*i +: 5] = a; db[32*i +: 32] = dt;
    endtask

    initial begin
        va = '0; aa = '0; da = '0;
        vb = '0; ab = '0; db = '0;
        repeat (3) step();
        #1;
        chk("reset_we", 0, we_a, 0);
        chk("reset_init", 0, id_a, 0);
        reset = 1'b0;

        // Full sweep after reset release
        for (int k = 1; k <= 31; k++) begin
            step();
            chk("t1_we", 0, we_a, 1);
            chk("t1_addr", 0, wa_a, k);
            chk("t1_data", 0, wd_a, 0);
            chk("t1_ready", 0, rdy_a, 0);
            chk("t1_init", 0, id_a, (k == 31));
            if (k == 1) begin
                chk("t6_init_b", 1, id_b, 1);
                chk("t6_nosweep_b", 1, we_b, 0);
            end
        end
        step();
        chk("t1_after_we", 0, we_a, 0);
        chk("t1_after_init", 0, id_a, 1);

        // Single requester
        set_a(0, 1, 5'd5, 32'hDEADBEEF);
        #1 chk("t2_ready", 0, rdy_a, 2'b01);
        step();
        set_a(0, 0, 5'd0, 32'h0);
        chk("t2_we", 0, we_a, 1);
        chk("t2_addr", 0, wa_a, 5);
        chk("t2_data", 0, wd_a, 32'hDEADBEEF);
        step();
        chk("t2_we_drop", 0, we_a, 0);
        chk("t2_addr_hold", 0, wa_a, 5);

        // Bring rr_ptr back to 0, then both requesters contend
        set_a(1, 1, 5'd9, 32'h99);
        step();
        set_a(1, 0, 5'd0, 32'h0);
        set_a(0, 1, 5'd3, 32'hA3);
        set_a(1, 1, 5'd7, 32'hB7);
        for (int c = 0; c < 4; c++) begin
            #1 chk("t3_ready", 0, rdy_a, (c % 2 == 0) ? 2'b01 : 2'b10);
            step();
            chk("t3_we", 0, we_a, 1);
            chk("t3_addr", 0, wa_a, (c % 2 == 0) ? 3 : 7);
        end
        set_a(0, 0, 5'd0, 32'h0);
        set_a(1, 0, 5'd0, 32'h0);
        chk("t3_cont", 0, ct_a, 4);

        // x0 write is consumed but dropped
        set_a(1, 1, 5'd0, 32'h1234);
        #1 chk("t4_ready", 0, rdy_a, 2'b10);
        step();
        set_a(1, 0, 5'd0, 32'h0);
        chk("t4_we", 0, we_a, 0);
        set_a(0, 1, 5'd3, 32'hA3);
        set_a(1, 1, 5'd7, 32'hB7);
        #1 chk("t4_rr_wrapped", 0, rdy_a, 2'b01);
        step();
        set_a(0, 0, 5'd0, 32'h0);
        set_a(1, 0, 5'd0, 32'h0);
        chk("t4_next_addr", 0, wa_a, 3);

        // Reset in RUN, then again mid-sweep
        reset = 1'b1;
        #1;
        chk("t5_rst_we", 0, we_a, 0);
        chk("t5_rst_cont", 0, ct_a, 0);
        chk("t5_rst_init", 0, id_a, 0);
        step();
        reset = 1'b0;
        repeat (12) step();
        chk("t5_mid_addr", 0, wa_a, 12);
        reset = 1'b1;
        #1;
        chk("t5_async_we", 0, we_a, 0);
        chk("t5_async_addr", 0, wa_a, 0);
        step();
        reset = 1'b0;
        set_a(0, 1, 5'd11, 32'h11);
        set_a(1, 1, 5'd12, 32'h12);
        for (int k = 1; k <= 31; k++) begin
            step();
            chk("t5_addr", 0, wa_a, k);
            chk("t5_we", 0, we_a, 1);
            chk("t5_ready", 0, rdy_a, (k == 31) ? 2'b01 : 2'b00);
            if (k == 1) chk("t6_init_b2", 1, id_b, 1);
        end
        step();
        chk("t5_first_addr", 0, wa_a, 11);
        chk("t5_first_data", 0, wd_a, 32'h11);
        step();
        chk("t5_second_addr", 0, wa_a, 12);
        set_a(0, 0, 5'd0, 32'h0);
        set_a(1, 0, 5'd0, 32'h0);

        // Saturating contention on the 3-requester instance
        set_b(0, 1, 5'd4, 32'h4);
        set_b(2, 1, 5'd6, 32'h6);
        #1 chk("t6_ready", 1, rdy_b, 3'b001);
        repeat (6) step();
        set_b(0, 0, 5'd0, 32'h0);
        set_b(2, 0, 5'd0, 32'h0);
        chk("t6_cont_sat", 1, ct_b, 3);

        // All three valid: one grant each, in order
        set_b(0, 1, 5'd1, 32'h101);
        set_b(1, 1, 5'd2, 32'h102);
        set_b(2, 1, 5'd3, 32'h103);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t7_addr", 1, wa_b, c + 1);
        end
        vb = '0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
